// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of a clocked 4:1 mux.
// It picks one of four requesters and drives the mux select. It then holds the
// select until the mux register has caught up, and presents the mux output as
// valid downstream. A requester is released by an ack pulse on the cycle the
// consumer takes the data.
module mux_rr_arbiter #(
    parameter int MUX_LATENCY = 1,
    parameter int NUM_REQ     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [1:0] ctrl,
    output logic [3:0] grant,
    output logic [3:0] ack,
    output logic       out_valid,
    output logic       busy
);

    // Elaboration guards: the select is 2 bits wide and the settle counter is 4 bits wide.
    generate
        if (NUM_REQ != 4) begin : g_bad_num_req
            $error("mux_rr_arbiter: NUM_REQ must be 4");
        end
        if ((MUX_LATENCY < 1) || (MUX_LATENCY > 15)) begin : g_bad_latency
            $error("mux_rr_arbiter: MUX_LATENCY must be within 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        VALID  = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MUX_LATENCY - 1);

    state_t     state_r;
    logic [1:0] rr_ptr_r;
    logic [3:0] cnt_r;
    logic [1:0] ctrl_r;
    logic [3:0] grant_r;
    logic       out_valid_r;
    logic       busy_r;

    logic [3:0] arb_req_s;
    logic [1:0] arb_ptr_s;
    logic [2:0] pick_s;
    logic       win_found_s;
    logic [1:0] win_idx_s;
    logic       xfer_s;

    // First set bit of r, searching upward from ptr with wrap-around. The result is {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + 2'(k);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                idx = idx;
            end
        end
        return {found, idx};
    endfunction

    // Arbitration inputs. On an ack the current owner is masked out, and the
    // search starts just past it, which is where rr_ptr is heading on this edge.
    always_comb begin
        arb_req_s = req;
        arb_ptr_s = rr_ptr_r;
        if (state_r == VALID) begin
            arb_req_s = req & ~grant_r;
            arb_ptr_s = ctrl_r + 2'd1;
        end else begin
            arb_req_s = req;
            arb_ptr_s = rr_ptr_r;
        end
    end

    assign pick_s      = rr_pick(arb_req_s, arb_ptr_s);
    assign win_found_s = pick_s[2];
    assign win_idx_s   = pick_s[1:0];

    // A transfer happens only while the output is valid and accepted. Reset suppresses it.
    assign xfer_s = out_valid_r & out_ready & ~rst;
    assign ack    = grant_r & {4{xfer_s}};

    assign ctrl      = ctrl_r;
    assign grant     = grant_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

    // Arbiter FSM: grant, settle through the mux latency, then present the output until it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rr_ptr_r    <= 2'd0;
            cnt_r       <= 4'd0;
            ctrl_r      <= 2'd0;
            grant_r     <= 4'd0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        ctrl_r  <= win_idx_s;
                        grant_r <= 4'b0001 << win_idx_s;
                        cnt_r   <= LAT_M1;
                        busy_r  <= 1'b1;
                        state_r <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_r == 4'd0) begin
                        out_valid_r <= 1'b1;
                        state_r     <= VALID;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                VALID: begin
                    if (out_ready) begin
                        rr_ptr_r    <= ctrl_r + 2'd1;
                        out_valid_r <= 1'b0;
                        if (win_found_s) begin
                            ctrl_r  <= win_idx_s;
                            grant_r <= 4'b0001 << win_idx_s;
                            cnt_r   <= LAT_M1;
                            state_r <= SETTLE;
                        end else begin
                            grant_r <= 4'd0;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rr_ptr_r    <= 2'd0;
                    cnt_r       <= 4'd0;
                    ctrl_r      <= 2'd0;
                    grant_r     <= 4'd0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter. The main instance (latency 1) is compared on
// every cycle against a transaction-level model: an owner index, the cycle
// its data becomes valid, and a priority pointer. Directed sequences add
// hand-computed literal checks. A second instance with latency 3 is checked
// with literals only.
module tb_mux_rr_arbiter;

    localparam int L = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] ctrl;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       out_valid;
    logic       busy;

    logic [3:0] req3;
    logic       ready3;
    logic [1:0] ctrl3;
    logic [3:0] grant3;
    logic [3:0] ack3;
    logic       out_valid3;
    logic       busy3;

    mux_rr_arbiter #(.MUX_LATENCY(L), .NUM_REQ(4)) dut (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
        .ctrl(ctrl), .grant(grant), .ack(ack), .out_valid(out_valid), .busy(busy)
    );

    mux_rr_arbiter #(.MUX_LATENCY(3), .NUM_REQ(4)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .out_ready(ready3),
        .ctrl(ctrl3), .grant(grant3), .ack(ack3), .out_valid(out_valid3), .busy(busy3)
    );

    // Clocked 4:1 mux fed by the arbiter select (one register stage, matching L=1)
    logic [63:0] in_data [4];
    logic [63:0] mux_out;
    always @(posedge clk) mux_out <= in_data[ctrl];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_owner = -1;   // index of the owning requester, -1 when idle
    int     m_ptr   = 0;    // highest-priority index
    int     m_ctrl  = 0;    // last select driven
    longint m_valid_at = 0; // cycle number at which the owner's data is valid
    longint cyc = 0;        // cycles elapsed (edges seen)
    bit     chk_en = 1'b0;
    int     m_w;
    bit     m_v;

    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int idx);
        logic [3:0] v;
        v = 4'd0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) begin
        m_v = (m_owner >= 0) && (cyc >= m_valid_at);
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_ctrl  = 0;
            chk_en  = 1'b1;
        end else if (m_owner < 0) begin
            m_w = pick(req, m_ptr);
            if (m_w >= 0) begin
                m_owner    = m_w;
                m_ctrl     = m_w;
                m_valid_at = cyc + 1 + L;
            end
        end else if (m_v && out_ready) begin
            m_ptr = (m_owner + 1) % 4;
            m_w   = pick(req & ~onehot(m_owner), m_ptr);
            if (m_w >= 0) begin
                m_owner    = m_w;
                m_ctrl     = m_w;
                m_valid_at = cyc + 1 + L;
            end else begin
                m_owner = -1;
            end
        end
        cyc++;
    end

    // Every-cycle comparison of the latency-1 instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic ev;
            ev = (m_owner >= 0) && (cyc >= m_valid_at);
            check("m_ctrl",  64'(ctrl),      64'(m_ctrl));
            check("m_grant", 64'(grant),     64'(onehot(m_owner)));
            check("m_valid", 64'(out_valid), 64'(ev));
            check("m_busy",  64'(busy),      64'(m_owner >= 0));
            check("m_ack",   64'(ack),       64'((ev && out_ready && !rst) ? onehot(m_owner) : 4'd0));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic lat3_run(input logic [3:0] r, input logic [1:0] idx);
        req3 = r;
        step();
        check("l3_ctrl1", 64'(ctrl3), 64'(idx));
        check("l3_grant", 64'(grant3), 64'(r));
        check("l3_val1", 64'(out_valid3), 64'd0);
        step();
        check("l3_ctrl2", 64'(ctrl3), 64'(idx));
        check("l3_val2", 64'(out_valid3), 64'd0);
        step();
        check("l3_ctrl3", 64'(ctrl3), 64'(idx));
        check("l3_val3", 64'(out_valid3), 64'd0);
        step();
        check("l3_ctrl4", 64'(ctrl3), 64'(idx));
        check("l3_val4", 64'(out_valid3), 64'd1);
        check("l3_ack", 64'(ack3), 64'(r));
        req3 = 4'd0;
        step();
        check("l3_idle", 64'(busy3), 64'd0);
    endtask

    logic [3:0]  rr_exp [5];
    logic [63:0] rr_val [4];

    initial begin
        rst = 1'b1; req = 4'd0; out_ready = 1'b0; req3 = 4'd0; ready3 = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i] = 64'd0;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        rr_val[0] = 64'd11; rr_val[1] = 64'd22; rr_val[2] = 64'd33; rr_val[3] = 64'd44;

        // Reset values
        step(); step();
        check("rst_ctrl", 64'(ctrl), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        rst = 1'b0;

        // Single request from in3
        in_data[2] = 64'd12345;
        req = 4'b0100; out_ready = 1'b1;
        step();
        check("single_ctrl", 64'(ctrl), 64'd2);
        check("single_grant", 64'(grant), 64'b0100);
        check("single_val0", 64'(out_valid), 64'd0);
        step();
        check("single_val1", 64'(out_valid), 64'd1);
        check("single_ack", 64'(ack), 64'b0100);
        check("single_data", mux_out, 64'd12345);
        req = 4'd0;
        step();
        check("single_idle", 64'(busy), 64'd0);
        check("single_ctrl_hold", 64'(ctrl), 64'd2);

        // Round-robin fairness with all four requesting
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 4; i++) in_data[i] = rr_val[i];
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_grant", 64'(grant), 64'(rr_exp[k]));
            check("rr_noack", 64'(ack), 64'd0);
            step();
            check("rr_ack", 64'(ack), 64'(rr_exp[k]));
            check("rr_data", mux_out, rr_val[k % 4]);
        end
        req = 4'd0;
        step();
        check("rr_idle", 64'(busy), 64'd0);

        // Backpressure on in2
        req = 4'b0010; out_ready = 1'b0;
        step();
        check("bp_grant", 64'(grant), 64'b0010);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_ctrl", 64'(ctrl), 64'd1);
            check("bp_grant_hold", 64'(grant), 64'b0010);
            check("bp_ack0", 64'(ack), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ack", 64'(ack), 64'b0010);
        req = 4'd0;
        step();
        check("bp_idle", 64'(busy), 64'd0);

        // Same requester re-requesting continuously
        req = 4'b0001;
        step();
        check("rq_grant1", 64'(grant), 64'b0001);
        step();
        check("rq_ack1", 64'(ack), 64'b0001);
        step();
        check("rq_gap_ack", 64'(ack), 64'd0);
        check("rq_gap_busy", 64'(busy), 64'd0);
        step();
        check("rq_grant2", 64'(grant), 64'b0001);
        step();
        check("rq_ack2", 64'(ack), 64'b0001);
        req = 4'd0;
        step();

        // Reset while VALID with out_ready high
        req = 4'b1000;
        step();
        check("rm_grant", 64'(grant), 64'b1000);
        step();
        check("rm_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rm_ack_gated", 64'(ack), 64'd0);
        step();
        check("rm_ctrl", 64'(ctrl), 64'd0);
        check("rm_grant0", 64'(grant), 64'd0);
        check("rm_valid0", 64'(out_valid), 64'd0);
        rst = 1'b0; req = 4'b1001;
        step();
        check("rm_first", 64'(grant), 64'b0001);
        step();
        check("rm_ack1", 64'(ack), 64'b0001);
        step();
        check("rm_second", 64'(grant), 64'b1000);
        step();
        check("rm_ack2", 64'(ack), 64'b1000);
        req = 4'd0;
        step();

        // Latency-3 instance: valid four cycles after the IDLE decision
        lat3_run(4'b0001, 2'd0);
        lat3_run(4'b0100, 2'd2);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
